// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential BCD-to-binary converter using reverse double dabble.
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   start   - request a conversion, sampled only in IDLE
//   bcd     - packed digits, units digit in bits [3:0]
//   busy    - high in every state except IDLE
//   ready   - one-cycle pulse when a conversion or rejection completes
//   value   - last successful binary result
//   error   - last accepted request contained a digit > 9
module bcd_to_binary #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  ready,
    output logic [BIN_W-1:0]      value,
    output logic                  error
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W);
    typedef enum logic [1:0] {IDLE, SHIFT, ADJUST, DONE} state_t;
    state_t state, state_next;
    logic [SW-1:0] sr, sr_next, sr_adj;
    logic [CW-1:0] count, count_next;
    logic [BIN_W-1:0] value_next;
    logic error_next, invalid;
    always_comb begin
        invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            invalid = invalid | (bcd[4*i +: 4] > 4'd9);
    end
    // Undo the doubling of the binary-to-BCD direction: nibbles that picked up
    // a 1 from the digit above (>= 8 after the shift) lose the extra 3.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < DIGITS; i++)
            sr_adj[BIN_W + 4*i +: 4] = (sr[BIN_W + 4*i +: 4] >= 4'd8) ?
                sr[BIN_W + 4*i +: 4] - 4'd3 : sr[BIN_W + 4*i +: 4];
    end
    always_comb begin
        state_next = state;
        sr_next    = sr;
        count_next = count;
        value_next = value;
        error_next = error;
        case (state)
            IDLE: if (start) begin
                if (invalid) begin
                    error_next = 1'b1;
                    state_next = DONE;
                end else begin
                    sr_next    = {bcd, {BIN_W{1'b0}}};
                    error_next = 1'b0;
                    count_next = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                sr_next    = sr >> 1;
                count_next = count + 1'b1;
                if (count_next == LAST) begin
                    value_next = sr_next[BIN_W-1:0];
                    state_next = DONE;
                end else begin
                    state_next = ADJUST;
                end
            end
            ADJUST: begin
                sr_next    = sr_adj;
                state_next = SHIFT;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sr    <= '0;
            count <= '0;
            value <= '0;
            error <= 1'b0;
        end else begin
            state <= state_next;
            sr    <= sr_next;
            count <= count_next;
            value <= value_next;
            error <= error_next;
        end
    end
    assign busy  = (state != IDLE);
    assign ready = (state == DONE);
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: randomized self-checking bench for bcd_to_binary against an arithmetic model.
module tb_bcd_to_binary;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bcd = '0;
    logic        busy, ready, error;
    logic [13:0] value;
    int          asserts = 0;
    int          fails = 0;
    logic [13:0] exp_value = '0;

    bcd_to_binary #(.DIGITS(4), .BIN_W(14)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .bcd(bcd),
        .busy(busy), .ready(ready), .value(value), .error(error)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] bcd_ref(input logic [15:0] b);
        int sum = 0;
        int p = 1;
        for (int i = 0; i < 4; i++) begin
            sum += int'(b[4*i +: 4]) * p;
            p *= 10;
        end
        return 14'(sum);
    endfunction

    // Issues one request and reports latency in cycles counted from the start
    // edge (inclusive), how many waiting cycles had busy low, and ready one
    // cycle after the pulse. Inputs are driven and outputs sampled #1 after edges.
    task automatic convert(input logic [15:0] b, output int lat, output int busy_bad,
                           output logic ready_after);
        start = 1'b1;
        bcd = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        busy_bad = 0;
        while (ready !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (busy !== 1'b1) busy_bad++;
        @(posedge clk);
        #1;
        ready_after = ready;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        asserts += 4;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready); end
        if (value !== 14'd0) begin fails++; $display("FAIL reset_value got %0d want 0", value); end
        if (error !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", error); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_max();
        int lat, bb;
        logic ra;
        convert(16'h9999, lat, bb, ra);
        exp_value = 14'd9999;
        asserts += 5;
        if (lat != 28) begin fails++; $display("FAIL max_latency got %0d want 28", lat); end
        if (value !== exp_value) begin fails++; $display("FAIL max_value got %0d want %0d", value, exp_value); end
        if (error !== 1'b0) begin fails++; $display("FAIL max_error got %b want 0", error); end
        if (bb != 0) begin fails++; $display("FAIL max_busy got %0d low cycles want 0", bb); end
        if (ra !== 1'b0) begin fails++; $display("FAIL max_ready_width got %b want 0", ra); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [3] = '{16'h0000, 16'h1234, 16'h0001};
        int lat, bb;
        logic ra;
        for (int k = 0; k < 3; k++) begin
            convert(seq[k], lat, bb, ra);
            exp_value = bcd_ref(seq[k]);
            asserts += 3;
            if (value !== exp_value) begin fails++; $display("FAIL b2b_value[%0d] got %0d want %0d", k, value, exp_value); end
            if (lat != 28) begin fails++; $display("FAIL b2b_latency[%0d] got %0d want 28", k, lat); end
            if (ra !== 1'b0) begin fails++; $display("FAIL b2b_ready_width[%0d] got %b want 0", k, ra); end
        end
    endtask

    task automatic test_invalid();
        int lat, bb;
        logic ra;
        convert(16'h12A4, lat, bb, ra);
        asserts += 4;
        if (lat != 1) begin fails++; $display("FAIL invalid_latency got %0d want 1", lat); end
        if (error !== 1'b1) begin fails++; $display("FAIL invalid_error got %b want 1", error); end
        if (value !== exp_value) begin fails++; $display("FAIL invalid_value got %0d want %0d", value, exp_value); end
        if (ra !== 1'b0) begin fails++; $display("FAIL invalid_ready_width got %b want 0", ra); end
        convert(16'h0042, lat, bb, ra);
        exp_value = 14'd42;
        asserts += 2;
        if (error !== 1'b0) begin fails++; $display("FAIL recover_error got %b want 0", error); end
        if (value !== exp_value) begin fails++; $display("FAIL recover_value got %0d want %0d", value, exp_value); end
    endtask

    task automatic test_ignore_start();
        int readies = 0;
        int lat = 0;
        start = 1'b1;
        bcd = 16'h0500;
        @(posedge clk);
        #1;
        for (int n = 1; n < 70; n++) begin
            if (ready === 1'b1) begin
                readies++;
                if (lat == 0) lat = n;
            end
            // keep start high through the DONE cycle too, it must be ignored there
            start = (ready === 1'b1) ? 1'b1 : (readies == 0) ? 1'($urandom % 2) : 1'b0;
            bcd = 16'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        exp_value = 14'd500;
        asserts += 4;
        if (readies != 1) begin fails++; $display("FAIL ignore_ready_count got %0d want 1", readies); end
        if (lat != 28) begin fails++; $display("FAIL ignore_latency got %0d want 28", lat); end
        if (value !== exp_value) begin fails++; $display("FAIL ignore_value got %0d want %0d", value, exp_value); end
        if (busy !== 1'b0) begin fails++; $display("FAIL ignore_idle got busy %b want 0", busy); end
    endtask

    task automatic test_async_reset();
        int readies = 0;
        int lat, bb;
        logic ra;
        start = 1'b1;
        bcd = 16'h8765;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        exp_value = 14'd0;
        asserts += 4;
        if (busy !== 1'b0) begin fails++; $display("FAIL areset_busy got %b want 0", busy); end
        if (ready !== 1'b0) begin fails++; $display("FAIL areset_ready got %b want 0", ready); end
        if (value !== exp_value) begin fails++; $display("FAIL areset_value got %0d want 0", value); end
        if (error !== 1'b0) begin fails++; $display("FAIL areset_error got %b want 0", error); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if (ready === 1'b1) readies++;
            @(posedge clk);
            #1;
        end
        asserts += 1;
        if (readies != 0) begin fails++; $display("FAIL areset_no_ready got %0d pulses want 0", readies); end
        convert(16'h8765, lat, bb, ra);
        exp_value = 14'd8765;
        asserts += 2;
        if (value !== exp_value) begin fails++; $display("FAIL areset_reconvert got %0d want %0d", value, exp_value); end
        if (lat != 28) begin fails++; $display("FAIL areset_latency got %0d want 28", lat); end
    endtask

    task automatic test_random();
        int lat, bb;
        logic ra;
        logic [15:0] b;
        for (int k = 0; k < 500; k++) begin
            for (int d = 0; d < 4; d++) b[4*d +: 4] = 4'($urandom_range(0, 9));
            convert(b, lat, bb, ra);
            exp_value = bcd_ref(b);
            asserts += 4;
            if (value !== exp_value) begin fails++; $display("FAIL rand_value bcd=%h got %0d want %0d", b, value, exp_value); end
            if (lat != 28) begin fails++; $display("FAIL rand_latency bcd=%h got %0d want 28", b, lat); end
            if (ra !== 1'b0) begin fails++; $display("FAIL rand_ready_width bcd=%h got %b want 0", b, ra); end
            if (error !== 1'b0) begin fails++; $display("FAIL rand_error bcd=%h got %b want 0", b, error); end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_back_to_back();
        test_invalid();
        test_ignore_start();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
Sequential BCD-to-binary converter using reverse double dabble (shift right, then subtract 3 from any nibble ≥ 8). It is the inverse of the display path's binary-to-BCD conversion. It takes a packed BCD number, for example a threshold or coordinate entered on the DE2 switches or keypad, and produces the binary value used by the image-processing datapath. Single start/ready handshake, one conversion in flight at a time.

Parameters:
DIGITS, 4, number of BCD digits at the input.
BIN_W, 14, output width in bits. Must satisfy 2^BIN_W > 10^DIGITS - 1; the default covers 0..9999.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request a conversion; sampled only in IDLE.
bcd  input  4*DIGITS  packed digits; digit0 (units) in bits [3:0], digit(DIGITS-1) in the MSBs.
busy  output  1  high in every state except IDLE.
ready  output  1  one-cycle pulse when a conversion or rejection completes.
value  output  BIN_W  binary result; holds the last successful result.
error  output  1  set when the last accepted request contained a digit > 9.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; value=0, ready=0, busy=0, error=0.
  - Internal shift register and iteration counter cleared.
  - Reset mid-conversion aborts it. No ready pulse; value keeps its reset value of 0.
- States: IDLE, SHIFT, ADJUST, DONE.
- IDLE, start=1 at edge E0:
  - Capture bcd.
  - If any nibble > 9: go to DONE with error=1. value is not modified.
  - Otherwise: load shift register {bcd_field[4*DIGITS], bin_field[BIN_W]} = {bcd, 0}; clear error; count=0; go to SHIFT.
- SHIFT:
  - Logical right shift of the whole register by 1. bin_field MSB receives the bcd_field LSB; a 0 enters at the top.
  - count increments.
  - If count reaches BIN_W on this shift: value <= new bin_field; go to DONE.
  - Otherwise go to ADJUST.
- ADJUST: every bcd_field nibble ≥ 8 is decreased by 3; other nibbles are unchanged. Go to SHIFT.
- DONE: ready=1 for exactly this cycle. Next state is IDLE.
- Latency, valid conversion:
  - BIN_W shifts and BIN_W-1 adjusts; value updates at edge E0+2*BIN_W-1.
  - ready is high in the following cycle, i.e. 28 cycles after E0 for the defaults.
  - The next start is accepted at the earliest one cycle after ready.
- Latency, rejected input: ready high in the cycle after E0; error=1 during and after ready.
- start outside IDLE (including DONE) is ignored; no queueing.
- bcd may change freely after E0; only the captured copy is used.
- error stays asserted until the next accepted start with valid digits, or until reset.
- value changes only on successful completion. It is stable between completions, so consumers may sample it at any time.
- Arithmetic: nibble subtraction is 4-bit. Inputs ≥ 8 only arise from valid states, so there is no underflow. No saturation is needed because BIN_W is sized for the maximum value.

Test Plan:
- Reset, then start with bcd=16'h9999 -> ready exactly 28 cycles after the start edge, value=14'd9999 (0x270F), error=0, busy high from cycle 1 through the DONE cycle.
- bcd=16'h0000, then 16'h1234, then 16'h0001 back-to-back with start one cycle after each ready -> value = 0, 1234, 1; exactly one ready pulse per request.
- bcd=16'h12A4 (digit1 = 0xA) -> ready in the cycle after start, error=1, value retains the prior result (1); a following start with 16'h0042 clears error and gives value=42.
- start pulsed repeatedly while busy, and bcd changed mid-conversion -> ignored; the result matches the originally captured digits (e.g. 16'h0500 -> 500); only one ready.
- reset_n asserted asynchronously 10 cycles into converting 16'h8765 -> busy, ready, error and value go to 0 immediately with no ready pulse afterwards; a subsequent conversion of 16'h8765 gives 8765.
- 500 random valid 4-digit BCD values, each compared against a reference model -> all match, latency always 28, ready always 1 cycle wide.
